// File: rtl/itoh_tsuji_ctrl_if.sv
// Control bundle between the Itoh-Tsuji sequencer (master) and the
// datapath / multiplier / host side (slave).
interface itoh_tsuji_ctrl_if;
    logic       start;
    logic       mul_ack;
    logic       busy;
    logic       done;
    logic       err;
    logic       ld_en;
    logic       sq_en;
    logic       acc_ld;
    logic       mul_req;
    logic [1:0] rd_sel;
    logic [1:0] wr_sel;
    logic [2:0] step;

    modport master (
        input  start, mul_ack,
        output busy, done, err, ld_en, sq_en, acc_ld, mul_req,
               rd_sel, wr_sel, step
    );

    modport slave (
        output start, mul_ack,
        input  busy, done, err, ld_en, sq_en, acc_ld, mul_req,
               rd_sel, wr_sel, step
    );
endinterface

// File: rtl/itoh_tsuji_ctrl.sv
// Sequencer for GF(2^8) inversion via the addition chain 1,2,3,6,7:
// a^-1 = (beta_7)^2. Pure control; never touches field data.
module itoh_tsuji_ctrl #(
    parameter int MUL_TO = 16,
    parameter int TO_W   = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    itoh_tsuji_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SQR, S_RD, S_MUL, S_WR, S_FINAL, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      step_q,  step_d;
    logic [1:0]      sq_q,    sq_d;
    logic [TO_W-1:0] to_q,    to_d;
    logic            err_q,   err_d;

    logic [1:0]      sq_last;
    logic [1:0]      ops;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MUL_TO - 1);

    // Chain table: step 3 squares three times and multiplies by beta_3 in slot1
    assign sq_last = (step_q == 3'd3) ? 2'd2 : 2'd0;
    assign ops     = (step_q == 3'd3) ? 2'b01 : 2'b00;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            step_q  <= 3'd0;
            sq_q    <= 2'd0;
            to_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            sq_q    <= sq_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        sq_d    = sq_q;
        to_d    = '0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    step_d  = 3'd1;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                state_d = S_SQR;
                sq_d    = 2'd0;
            end
            S_SQR: begin
                if (sq_q == sq_last) begin
                    sq_d    = 2'd0;
                    state_d = S_RD;
                end else begin
                    sq_d = sq_q + 2'd1;
                end
            end
            S_RD: state_d = S_MUL;
            S_MUL: begin
                // Timeout counter only runs here; every other state holds it at 0
                if (bus.mul_ack) begin
                    if (step_q == 3'd2) begin
                        state_d = S_WR;
                    end else if (step_q == 3'd4) begin
                        state_d = S_FINAL;
                    end else begin
                        step_d  = step_q + 3'd1;
                        state_d = S_SQR;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WR: begin
                step_d  = step_q + 3'd1;
                state_d = S_SQR;
            end
            S_FINAL: state_d = S_DONE;
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                step_d  = 3'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.ld_en   = 1'b0;
        bus.sq_en   = 1'b0;
        bus.acc_ld  = 1'b0;
        bus.mul_req = 1'b0;
        bus.rd_sel  = 2'b00;
        bus.wr_sel  = 2'b00;
        bus.err     = err_q;
        bus.step    = step_q;
        case (state_q)
            S_LOAD: begin
                bus.busy   = 1'b1;
                bus.ld_en  = 1'b1;
                bus.wr_sel = 2'b10;
            end
            S_SQR: begin
                bus.busy  = 1'b1;
                bus.sq_en = 1'b1;
            end
            S_RD: begin
                bus.busy   = 1'b1;
                bus.rd_sel = ops;
            end
            S_MUL: begin
                // Storage read is registered, so rd_sel must stay put for the whole wait
                bus.busy    = 1'b1;
                bus.mul_req = 1'b1;
                bus.acc_ld  = bus.mul_ack;
                bus.rd_sel  = ops;
            end
            S_WR: begin
                bus.busy   = 1'b1;
                bus.wr_sel = 2'b01;
            end
            S_FINAL: begin
                bus.busy  = 1'b1;
                bus.sq_en = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/itoh_tsuji_ctrl.md
Name: itoh_tsuji_ctrl

Overview:
- Sequencing FSM for the GF(2^8) Itoh-Tsuji inversion datapath.
- Drives the two-slot beta_k storage bank (write/read selects), the working-register squarer enable and load strobes, and a request/acknowledge handshake to a variable-latency field multiplier.
- Computes a^-1 = (beta_7)^2 using the fixed addition chain 1,2,3,6,7.
- Data-independent: it never sees field data, only control.

Parameters:
- MUL_TO, 16: maximum cycles mul_req may stay high without mul_ack before abort.
- TO_W, 5: width of the timeout counter; must hold MUL_TO.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  begin inversion; sampled only in IDLE.
- mul_ack  in  1  single-cycle pulse; multiplier product valid this cycle.
- busy  out  1  high from LOAD through FINAL.
- done  out  1  one-cycle pulse; working register holds a^-1.
- err  out  1  multiplier timeout flag; held until next accepted start.
- ld_en  out  1  load input operand a into working register.
- sq_en  out  1  working register <= working register squared, this cycle.
- acc_ld  out  1  working register <= multiplier product.
- mul_req  out  1  multiply request (working reg x storage data_read).
- rd_sel  out  2  storage read select (00 = slot0, 01 = slot1).
- wr_sel  out  2  storage write select (00 = none, 10 = slot0, 01 = slot1).
- step  out  3  current chain step, 0-4; status only.

Behaviour:
- Reset: state = IDLE. All outputs are 0, including rd_sel, wr_sel and step. Timeout and square counters are 0. Reset mid-operation aborts immediately; no done is produced.
- Storage read is registered: data_read is valid one cycle after rd_sel is driven. rd_sel holds its value from RD through the end of MUL.
- States:
  - IDLE: start=1 -> LOAD. Clears err.
  - LOAD (1 cycle): ld_en=1, wr_sel=10 (slot0 <= a = beta_1). Sets step=1. -> SQR.
  - SQR: sq_en=1 for N(step) consecutive cycles, then -> RD.
  - RD (1 cycle): rd_sel = OPS(step). -> MUL.
  - MUL: mul_req=1 each cycle.
    - When mul_ack=1: acc_ld=1 in that same cycle and mul_req stays 1 in it. Next state is WR if step==2; otherwise step advances.
    - If MUL_TO cycles elapse with no ack: -> ERR.
  - WR (1 cycle): wr_sel=01 (slot1 <= beta_3). Then step advances.
  - Step advance: step==4 -> FINAL; otherwise step+1 -> SQR.
  - FINAL (1 cycle): sq_en=1. -> DONE.
  - DONE (1 cycle): done=1, busy=0. -> IDLE.
  - ERR (1 cycle): err=1 (latched), done=0, busy=0. -> IDLE.
- Chain table (step: squarings N, operand slot OPS, result):
  - 1: N=1, slot0, beta_2.
  - 2: N=1, slot0, beta_3 (stored to slot1).
  - 3: N=3, slot1, beta_6.
  - 4: N=1, slot0, beta_7.
- Only one of ld_en, sq_en and acc_ld is high in any cycle.
- start is ignored outside IDLE, including in the DONE cycle.
- A mul_ack outside MUL is ignored.
- Latency with mul_ack in the first MUL cycle: start sampled at edge E0, LOAD in cycle 1, done high in cycle 18. Each extra multiplier wait cycle adds 1.
- The timeout counter resets on entry to each MUL state.
- a=0: the datapath yields 0; the controller sequence is unchanged.

Test Plan:
- Reset, then start pulse; mul_ack returns in the first MUL cycle; datapath model uses irreducible polynomial 0x11B with a=0x02 -> done in cycle 18, working register = 0x8D, err=0, exactly 7 sq_en cycles, 4 mul_req handshakes.
- Sweep a = 0x01..0xFF with the same model -> every result r satisfies a*r = 0x01. a=0x00 -> result 0x00.
- Random 0-5 cycle mul_ack delay per multiply, a=0x53 -> result 0xCA. done cycle = 18 + total delay. rd_sel stable throughout each MUL.
- mul_ack held low in step 3 -> ERR after 16 MUL cycles. err=1 and busy=0 from the next cycle, no done. The next start clears err and completes normally.
- start re-pulsed while busy and in the DONE cycle -> ignored, exactly one done per accepted start.
- RST_N asserted during SQR of step 3 -> all outputs 0 asynchronously. After release, state is IDLE and a new start completes in 18 cycles.
